// File: rtl/bitstream_serializer.sv
`timescale 1ns/1ps
// bitstream_serializer
//   Merges the parallel per-lane bitstream packets of the entropy encoder into
//   a single byte stream. Accepted lane groups are written (non-empty lanes
//   only, ascending lane order) into a packet FIFO; the head packet is then
//   expanded byte by byte, including the run-length carry forms (flags 5-7).
//
// Ports
//   ser_clk       clock, rising edge
//   ser_reset     asynchronous, active-low reset
//   in_bits       lane L byte k (k=1..5) at offset (L*5+k-1)*BITSTREAM_WIDTH
//   in_flag       lane L flag at [L*3+2:L*3]
//   in_valid      lane group valid
//   in_ready      group accepted when in_valid && in_ready
//   in_final      end-of-frame marker
//   out_byte      serial byte
//   out_valid     out_byte valid
//   out_ready     sink accepts
//   out_done      one-cycle pulse once the frame is fully drained
//   out_count     bytes accepted downstream in the current frame (saturating)
//   err_overflow  sticky: group offered while in_ready was low
//   err_flag      sticky: flag 4 seen on an accepted group
module bitstream_serializer #(
  parameter int NUM_LANES       = 3,
  parameter int BITSTREAM_WIDTH = 8,
  parameter int FIFO_DEPTH      = 8,
  parameter int COUNT_WIDTH     = 32
) (
  input  logic                                   ser_clk,
  input  logic                                   ser_reset,
  input  logic [NUM_LANES*5*BITSTREAM_WIDTH-1:0] in_bits,
  input  logic [NUM_LANES*3-1:0]                 in_flag,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   in_final,
  output logic [BITSTREAM_WIDTH-1:0]             out_byte,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   out_done,
  output logic [COUNT_WIDTH-1:0]                 out_count,
  output logic                                   err_overflow,
  output logic                                   err_flag
);

  localparam int W     = BITSTREAM_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DIRECT, S_HEAD, S_RUN, S_TAIL4, S_TAIL5
  } state_t;

  logic [5*W-1:0]   fifo_bytes [FIFO_DEPTH];
  logic [2:0]       fifo_flag  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_inc, src_ptr;
  logic [OCC_W-1:0] occupancy, push_count;
  logic             final_pending;

  logic                   accept, flag4_seen;
  logic [NUM_LANES-1:0]   lane_we;
  logic [PTR_W-1:0]       lane_slot [NUM_LANES];

  state_t         state, state_next;
  logic [2:0]     idx, idx_next;
  logic [W-1:0]   run_cnt, run_cnt_next;
  logic [W-1:0]   byte_next;
  logic           valid_next;
  logic [5*W-1:0] head_word;
  logic [2:0]     head_flag;
  logic           handshake, is_last, pop, load, src_avail;

  assign accept    = in_valid && in_ready;
  assign in_ready  = (occupancy <= OCC_W'(FIFO_DEPTH - NUM_LANES)) && !final_pending;
  assign out_done  = final_pending && (occupancy == '0) && (state == S_IDLE) && !out_valid;
  assign handshake = out_valid && out_ready;
  assign pop       = handshake && is_last;
  assign load      = (state == S_IDLE) || pop;
  assign head_word = fifo_bytes[rd_ptr];
  assign head_flag = fifo_flag[rd_ptr];
  assign rd_inc    = PTR_W'((32'(rd_ptr) + 32'd1) % 32'(FIFO_DEPTH));
  // When the head is retiring, the next packet is loaded on the same edge so
  // there is no idle cycle between packets.
  assign src_ptr   = pop ? rd_inc : rd_ptr;
  assign src_avail = pop ? (occupancy > OCC_W'(1)) : (occupancy != '0);

  // Compact the non-empty lanes of an accepted group into consecutive slots.
  always_comb begin
    push_count = '0;
    flag4_seen = 1'b0;
    lane_we    = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      logic [2:0] lane_flag;
      lane_flag    = in_flag[l*3 +: 3];
      lane_slot[l] = PTR_W'((32'(wr_ptr) + 32'(push_count)) % 32'(FIFO_DEPTH));
      lane_we[l]   = accept && (lane_flag != 3'd0) && (lane_flag != 3'd4);
      if (accept && (lane_flag == 3'd4)) flag4_seen = 1'b1;
      if (lane_we[l]) push_count = push_count + OCC_W'(1);
    end
  end

  always_ff @(posedge ser_clk) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (lane_we[l]) begin
        fifo_bytes[lane_slot[l]] <= in_bits[l*5*W +: 5*W];
        fifo_flag[lane_slot[l]]  <= in_flag[l*3 +: 3];
      end
    end
  end

  // Is the byte currently presented the final byte of the head packet?
  always_comb begin
    is_last = 1'b0;
    case (state)
      S_DIRECT: is_last = (idx == head_flag);
      S_HEAD:   is_last = (head_flag == 3'd5) && (head_word[2*W +: W] == '0);
      S_RUN:    is_last = (head_flag == 3'd5) && (run_cnt == W'(1));
      S_TAIL4:  is_last = (head_flag == 3'd6);
      S_TAIL5:  is_last = 1'b1;
      default:  is_last = 1'b0;
    endcase
  end

  // Expansion FSM: idx is the 1-based position within a direct packet, run_cnt
  // the number of b2 repeats still to present including the current one.
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    run_cnt_next = run_cnt;
    byte_next    = out_byte;
    valid_next   = out_valid;
    if (load) begin
      if (src_avail) begin
        valid_next = 1'b1;
        byte_next  = fifo_bytes[src_ptr][W-1:0];
        if (fifo_flag[src_ptr] >= 3'd5) begin
          state_next = S_HEAD;
        end else begin
          state_next = S_DIRECT;
          idx_next   = 3'd1;
        end
      end else begin
        state_next = S_IDLE;
        valid_next = 1'b0;
      end
    end else if (handshake) begin
      case (state)
        S_DIRECT: begin
          idx_next  = idx + 3'd1;
          byte_next = head_word[int'(idx)*W +: W];
        end
        S_HEAD: begin
          if (head_word[2*W +: W] != '0) begin
            state_next   = S_RUN;
            run_cnt_next = head_word[2*W +: W];
            byte_next    = head_word[W +: W];
          end else begin
            state_next = S_TAIL4;
            byte_next  = head_word[3*W +: W];
          end
        end
        S_RUN: begin
          if (run_cnt > W'(1)) begin
            run_cnt_next = run_cnt - W'(1);
            byte_next    = head_word[W +: W];
          end else begin
            state_next = S_TAIL4;
            byte_next  = head_word[3*W +: W];
          end
        end
        S_TAIL4: begin
          state_next = S_TAIL5;
          byte_next  = head_word[4*W +: W];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ser_clk or negedge ser_reset) begin
    if (!ser_reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      run_cnt       <= '0;
      out_byte      <= '0;
      out_valid     <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occupancy     <= '0;
      final_pending <= 1'b0;
      out_count     <= '0;
      err_overflow  <= 1'b0;
      err_flag      <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      run_cnt   <= run_cnt_next;
      out_byte  <= byte_next;
      out_valid <= valid_next;
      wr_ptr    <= PTR_W'((32'(wr_ptr) + 32'(push_count)) % 32'(FIFO_DEPTH));
      if (pop) rd_ptr <= rd_inc;
      occupancy <= occupancy + push_count - OCC_W'(pop);
      // A new in_final in the done cycle starts the next frame's wait.
      final_pending <= (final_pending && !out_done) || in_final;
      if (out_done) begin
        out_count <= '0;
      end else if (handshake && (out_count != '1)) begin
        out_count <= out_count + COUNT_WIDTH'(1);
      end
      if (in_valid && !in_ready) err_overflow <= 1'b1;
      if (flag4_seen) err_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bitstream_serializer.sv
`timescale 1ns/1ps
// tb_bitstream_serializer
//   Directed and randomized checks of bitstream_serializer. Expected bytes come
//   from a packet-expansion model feeding a byte queue; a negedge monitor
//   compares every handshaken byte and checks that stalled bytes hold.
module tb_bitstream_serializer;

  localparam int NUM_LANES = 3;
  localparam int W         = 8;

  logic                       ser_clk = 1'b0;
  logic                       ser_reset;
  logic [NUM_LANES*5*W-1:0]   in_bits;
  logic [NUM_LANES*3-1:0]     in_flag;
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_final;
  logic [W-1:0]               out_byte;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_done;
  logic [31:0]                out_count;
  logic                       err_overflow;
  logic                       err_flag;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          frame_bytes  = 0;
  logic [7:0]  exp_q [$];
  logic        stall_pending = 1'b0;
  logic [7:0]  stall_byte    = '0;
  logic [7:0]  grp_bytes [NUM_LANES][5];
  logic [2:0]  grp_flag  [NUM_LANES];
  logic [7:0]  t3_exp [6] = '{8'h40, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02};

  bitstream_serializer #(
    .NUM_LANES(NUM_LANES), .BITSTREAM_WIDTH(W), .FIFO_DEPTH(8), .COUNT_WIDTH(32)
  ) dut (
    .ser_clk(ser_clk), .ser_reset(ser_reset), .in_bits(in_bits), .in_flag(in_flag),
    .in_valid(in_valid), .in_ready(in_ready), .in_final(in_final),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .out_done(out_done), .out_count(out_count),
    .err_overflow(err_overflow), .err_flag(err_flag)
  );

  always #5 ser_clk = ~ser_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge ser_clk);
    #1;
  endtask

  task automatic clearGroup();
    for (int l = 0; l < NUM_LANES; l++) begin
      grp_flag[l] = 3'd0;
      for (int k = 0; k < 5; k++) grp_bytes[l][k] = 8'h00;
    end
  endtask

  task automatic setLane(input int l, input logic [2:0] f, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3,
                         input logic [7:0] b4, input logic [7:0] b5);
    grp_flag[l]     = f;
    grp_bytes[l][0] = b1;
    grp_bytes[l][1] = b2;
    grp_bytes[l][2] = b3;
    grp_bytes[l][3] = b4;
    grp_bytes[l][4] = b5;
  endtask

  // Reference model: byte sequence each packet stands for, lanes in order.
  task automatic modelPush();
    for (int l = 0; l < NUM_LANES; l++) begin
      int f;
      f = int'(grp_flag[l]);
      if (f >= 1 && f <= 3) begin
        for (int k = 0; k < f; k++) exp_q.push_back(grp_bytes[l][k]);
      end else if (f >= 5) begin
        exp_q.push_back(grp_bytes[l][0]);
        for (int r = 0; r < int'(grp_bytes[l][2]); r++) exp_q.push_back(grp_bytes[l][1]);
        if (f >= 6) exp_q.push_back(grp_bytes[l][3]);
        if (f == 7) exp_q.push_back(grp_bytes[l][4]);
      end
    end
  endtask

  task automatic applyStimulus(input logic accept, input logic final_flag);
    for (int l = 0; l < NUM_LANES; l++) begin
      in_flag[l*3 +: 3] = grp_flag[l];
      for (int k = 0; k < 5; k++) in_bits[(l*5+k)*W +: W] = grp_bytes[l][k];
    end
    in_valid = 1'b1;
    in_final = final_flag;
    if (accept) modelPush();
    tick();
    in_valid = 1'b0;
    in_final = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_queue_empty"}, exp_q.size(), 0);
    checkOutput({tag, "_idle"}, {31'd0, out_valid}, 0);
  endtask

  // Scoreboard and stall monitor, sampled half a cycle before each edge.
  always @(negedge ser_clk) begin
    if (!ser_reset) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        checkOutput("stall_valid", {31'd0, out_valid}, 1);
        checkOutput("stall_byte", {24'd0, out_byte}, {24'd0, stall_byte});
      end
      if (out_valid && out_ready) begin
        checkOutput("byte_expected", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          checkOutput("byte_value", {24'd0, out_byte}, {24'd0, exp_q.pop_front()});
        end
        frame_bytes++;
      end
      stall_pending = out_valid && !out_ready;
      stall_byte    = out_byte;
    end
  end

  initial begin
    logic exp_err_flag;
    int   waited;
    ser_reset = 1'b0;
    in_bits   = '0;
    in_flag   = '0;
    in_valid  = 1'b0;
    in_final  = 1'b0;
    out_ready = 1'b1;
    clearGroup();
    tick();
    tick();
    checkOutput("rst_in_ready", {31'd0, in_ready}, 1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 0);
    checkOutput("rst_out_byte", {24'd0, out_byte}, 0);
    checkOutput("rst_out_done", {31'd0, out_done}, 0);
    checkOutput("rst_out_count", out_count, 0);
    checkOutput("rst_errors", {30'd0, err_overflow, err_flag}, 0);
    ser_reset = 1'b1;
    tick();

    // Lanes (2,0,1): bytes back to back starting one edge after acceptance.
    clearGroup();
    setLane(0, 3'd2, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00);
    setLane(2, 3'd1, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0);
    checkOutput("lat_not_yet", {31'd0, out_valid}, 0);
    tick(); checkOutput("t2_v0", {31'd0, out_valid}, 1); checkOutput("t2_b0", {24'd0, out_byte}, 32'h11);
    tick(); checkOutput("t2_v1", {31'd0, out_valid}, 1); checkOutput("t2_b1", {24'd0, out_byte}, 32'h22);
    tick(); checkOutput("t2_v2", {31'd0, out_valid}, 1); checkOutput("t2_b2", {24'd0, out_byte}, 32'h33);
    tick(); checkOutput("t2_idle", {31'd0, out_valid}, 0); checkOutput("t2_count", out_count, 3);

    // Flag 7 run-length packet, then flag 5 with zero repeats.
    clearGroup();
    setLane(0, 3'd7, 8'h40, 8'hFF, 8'h03, 8'h01, 8'h02);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("t3_valid", {31'd0, out_valid}, 1);
      checkOutput("t3_byte", {24'd0, out_byte}, {24'd0, t3_exp[i]});
    end
    tick(); checkOutput("t3_idle", {31'd0, out_valid}, 0);
    clearGroup();
    setLane(0, 3'd5, 8'h40, 8'hFF, 8'h00, 8'h01, 8'h02);
    applyStimulus(1'b1, 1'b0);
    tick(); checkOutput("t3z_byte", {24'd0, out_byte}, 32'h40); checkOutput("t3z_valid", {31'd0, out_valid}, 1);
    tick(); checkOutput("t3z_idle", {31'd0, out_valid}, 0);

    // Toggled out_ready during a flag-3 packet.
    clearGroup();
    setLane(1, 3'd3, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00);
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      out_ready = ~out_ready;
      tick();
    end
    drain("t4", 20);

    // Fill with out_ready low: third group overflows and is dropped.
    out_ready = 1'b0;
    clearGroup();
    for (int l = 0; l < NUM_LANES; l++) setLane(l, 3'd1, 8'(8'h50 + l), 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_ready_after1", {31'd0, in_ready}, 1);
    for (int l = 0; l < NUM_LANES; l++) setLane(l, 3'd1, 8'(8'h60 + l), 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_ready_after2", {31'd0, in_ready}, 0);
    for (int l = 0; l < NUM_LANES; l++) setLane(l, 3'd1, 8'(8'h70 + l), 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_overflow", {31'd0, err_overflow}, 1);
    drain("t5", 40);

    // in_final with nothing pending: done right after the next edge.
    in_final = 1'b1;
    tick();
    in_final = 1'b0;
    checkOutput("fe_done", {31'd0, out_done}, 1);
    checkOutput("fe_count", out_count, frame_bytes);
    tick();
    checkOutput("fe_done_clear", {31'd0, out_done}, 0);
    checkOutput("fe_count_clear", out_count, 0);
    frame_bytes = 0;

    // in_final together with a flag-2 group.
    clearGroup();
    setLane(1, 3'd2, 8'hC1, 8'hC2, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b1);
    checkOutput("t6_ready_low", {31'd0, in_ready}, 0);
    checkOutput("t6_no_done", {31'd0, out_done}, 0);
    tick(); checkOutput("t6_b0", {24'd0, out_byte}, 32'hC1);
    tick(); checkOutput("t6_b1", {24'd0, out_byte}, 32'hC2); checkOutput("t6_no_done2", {31'd0, out_done}, 0);
    tick(); checkOutput("t6_done", {31'd0, out_done}, 1); checkOutput("t6_count", out_count, 2);
    tick(); checkOutput("t6_done_clear", {31'd0, out_done}, 0); checkOutput("t6_count_clear", out_count, 0);
    checkOutput("t6_ready_back", {31'd0, in_ready}, 1);
    frame_bytes = 0;

    // Flag 4 on lane 1: flagged, neighbours still emitted.
    clearGroup();
    setLane(0, 3'd1, 8'hD0, 8'h00, 8'h00, 8'h00, 8'h00);
    setLane(1, 3'd4, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
    setLane(2, 3'd2, 8'hD1, 8'hD2, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t7_err_flag", {31'd0, err_flag}, 1);
    drain("t7", 20);

    // Reset in the middle of a long run.
    clearGroup();
    setLane(0, 3'd6, 8'hE0, 8'hE1, 8'd20, 8'hE3, 8'hE4);
    applyStimulus(1'b1, 1'b0);
    repeat (4) tick();
    ser_reset = 1'b0;
    #1;
    exp_q.delete();
    frame_bytes = 0;
    checkOutput("t8_valid", {31'd0, out_valid}, 0);
    checkOutput("t8_byte", {24'd0, out_byte}, 0);
    checkOutput("t8_count", out_count, 0);
    checkOutput("t8_done", {31'd0, out_done}, 0);
    checkOutput("t8_ready", {31'd0, in_ready}, 1);
    checkOutput("t8_errors", {30'd0, err_overflow, err_flag}, 0);
    tick();
    ser_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("t8_no_partial", {31'd0, out_valid}, 0);
    end

    // Randomized groups with random backpressure.
    exp_err_flag = 1'b0;
    for (int g = 0; g < 120; g++) begin
      waited = 0;
      while (!in_ready && waited < 200) begin
        out_ready = ($urandom_range(3) != 0);
        tick();
        waited++;
      end
      checkOutput("rand_in_ready", {31'd0, in_ready}, 1);
      clearGroup();
      for (int l = 0; l < NUM_LANES; l++) begin
        setLane(l, 3'($urandom_range(7)), 8'($urandom), 8'($urandom),
                8'($urandom_range(4)), 8'($urandom), 8'($urandom));
        if (grp_flag[l] == 3'd4) exp_err_flag = 1'b1;
      end
      out_ready = ($urandom_range(3) != 0);
      applyStimulus(1'b1, 1'b0);
    end
    drain("rand", 2000);
    checkOutput("rand_overflow", {31'd0, err_overflow}, 0);
    checkOutput("rand_err_flag", {31'd0, err_flag}, {31'd0, exp_err_flag});
    checkOutput("rand_count", out_count, frame_bytes);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
